mem_initiator: RTL and testbench

Bus-master side of the pipeline's simple memory protocol: it takes one cache-line request (read fill or write-back) from the cache controller and turns it into `bsize` sequential single-word `re`/`we` accesses. For each word it holds the request lines until the memory responder pulses `MemValid`. It sits between the cache controller and the memory model or backing store. It assembles read lines, streams write lines, and signals completion with a one-cycle `Done`.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_initiator_if.sv | 31 +++
 rtl/mem_watchdog.sv | 28 ++
 rtl/mem_initiator.sv | 118 +++++++++++
 tb/tb_mem_initiator.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory protocol initiator.
// The ERROR state exists only when MEM_TIMEOUT_EN is defined.
package mem_pkg;

    localparam int unsigned BSIZE_DEF = 4;
    localparam int unsigned BYTE_OFF  = 2;
    localparam int unsigned IDX_W_DEF = $clog2(BSIZE_DEF);

    // Word-offset width for a line of n words; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StAccess = 3'd1,
        StGap    = 3'd2,
`ifdef MEM_TIMEOUT_EN
        StDone   = 3'd3,
        StError  = 3'd4
`else
        StDone   = 3'd3
`endif
    } state_e;

endpackage

// File: rtl/mem_initiator_if.sv
// Signal bundle between the cache controller, mem_initiator and the memory responder.
// master = initiator side, slave = controller/responder side.
interface mem_initiator_if
    import mem_pkg::*;
#(
    parameter int unsigned bsize = BSIZE_DEF
);
    logic                   Req;
    logic                   Write;
    logic [31:0]            BlockA;
    logic [32*bsize-1:0]    WLine;
    logic [32*bsize-1:0]    RLine;
    logic                   Done;
    logic                   Error;
    logic                   MemRE;
    logic                   MemWE;
    logic [31:0]            MemA;
    logic [31:0]            MemWD;
    logic [31:0]            MemRD;
    logic                   MemValid;

    modport master (
        input  Req, Write, BlockA, WLine, MemRD, MemValid,
        output RLine, Done, Error, MemRE, MemWE, MemA, MemWD
    );

    modport slave (
        output Req, Write, BlockA, WLine, MemRD, MemValid,
        input  RLine, Done, Error, MemRE, MemWE, MemA, MemWD
    );
endinterface

// File: rtl/mem_watchdog.sv
// ACCESS-phase watchdog: clearable, enabled up-counter with a terminal-count flag.
// tc is high in the TIMEOUT-th enabled cycle after a clear.
module mem_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CW'(TIMEOUT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_initiator.sv
// Memory protocol initiator: turns one cache-line request into bsize single-word accesses.
// Define MEM_TIMEOUT_EN to add the ACCESS watchdog and the ERROR state.
module mem_initiator
    import mem_pkg::*;
#(
    parameter int unsigned bsize   = BSIZE_DEF,
    parameter int unsigned TIMEOUT = 64
) (
    input logic             clk,
    input logic             reset,
    mem_initiator_if.master bus
);
    localparam int unsigned IW = idx_width(bsize);
    localparam int unsigned LW = 32 * bsize;
    localparam int unsigned AW = 32 - IW - BYTE_OFF;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic          wr_q;
    logic [AW-1:0] blk_q;
    logic [LW-1:0] wline_q;
    logic [LW-1:0] rline_q;
    logic          in_access;
    logic          last_word;

    assign in_access = (state_q == StAccess);
    assign last_word = (idx_q == IW'(bsize - 1));

    // Word offset bits of the line address are replaced by idx.
    logic unused_addr;
    assign unused_addr = ^bus.BlockA[IW+BYTE_OFF-1:0];

`ifdef MEM_TIMEOUT_EN
    logic tmo;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_access),
        .en    (in_access),
        .tc    (tmo)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.Req) state_d = StAccess;
            end
            StAccess: begin
                // A response in the terminal-count cycle still completes normally.
                if (bus.MemValid) state_d = last_word ? StDone : StGap;
`ifdef MEM_TIMEOUT_EN
                else if (tmo) state_d = StError;
`endif
            end
            StGap:   state_d = StAccess;
            StDone:  state_d = StIdle;
`ifdef MEM_TIMEOUT_EN
            StError: state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            wr_q    <= 1'b0;
            blk_q   <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else if ((state_q == StIdle) && bus.Req) begin
            idx_q   <= '0;
            wr_q    <= bus.Write;
            blk_q   <= bus.BlockA[31:IW+BYTE_OFF];
            wline_q <= bus.WLine;
        end else if (in_access && bus.MemValid) begin
            if (!wr_q) rline_q[idx_q*32 +: 32] <= bus.MemRD;
            if (!last_word) idx_q <= idx_q + 1'b1;
        end
    end

    // Outputs decode state and latched data only; nothing combinational from MemValid/MemRD.
    always_comb begin
        bus.MemRE = in_access & ~wr_q;
        bus.MemWE = in_access & wr_q;
        bus.MemA  = '0;
        bus.MemWD = '0;
        if (in_access) begin
            bus.MemA  = {blk_q, idx_q, 2'b00};
            bus.MemWD = wline_q[idx_q*32 +: 32];
        end
        bus.RLine = rline_q;
`ifdef MEM_TIMEOUT_EN
        bus.Done  = (state_q == StDone) || (state_q == StError);
        bus.Error = (state_q == StError);
`else
        bus.Done  = (state_q == StDone);
        bus.Error = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator: cycle-timeline model, memory responder, directed cases.
// Define MEM_TIMEOUT_EN to include the watchdog cases.
module tb_mem_initiator;
    localparam int BSIZE = 4;
    localparam int LW    = 32 * BSIZE;
    localparam int TMO   = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mem_initiator_if #(.bsize(BSIZE)) bus ();

    mem_initiator #(
        .bsize   (BSIZE),
        .TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          re;
        logic          we;
        logic [31:0]   a;
        logic [31:0]   wd;
        logic          done;
        logic          err;
        logic          rchk;
        logic [LW-1:0] rline;
    } exp_t;

    exp_t          tl[$];
    logic [31:0]   mem[0:1023];
    logic [31:0]   alog[$];
    longint        rq[$];
    logic [LW-1:0] exp_rline = '0;
    int            checks = 0;
    int            fails  = 0;
    longint        cyc = 0;
    longint        start_cyc = 0;
    longint        done_cyc = 0;
    longint        err_cyc = -1;
    int            done_cnt = 0;
    int            err_cnt = 0;
    int            re_cnt = 0;
    int unsigned   rwait = 1;
    bit            silent = 0;
    bit            inject = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic exp_t idle_e();
        exp_t e;
        e.re = 0; e.we = 0; e.a = '0; e.wd = '0;
        e.done = 0; e.err = 0; e.rchk = 0; e.rline = '0;
        return e;
    endfunction

    // Per-cycle expected outputs, derived from the word/gap/done timing rules.
    task automatic build(input bit wr, input logic [31:0] ba, input logic [LW-1:0] wl,
                         input int k, input bit sil);
        exp_t        e;
        logic [31:0] base = ba & ~(32'(BSIZE * 4) - 32'd1);
        tl.push_back(idle_e());
        for (int i = 0; i < BSIZE; i++) begin
            for (int c = 0; c < (sil ? TMO : k + 1); c++) begin
                e = idle_e(); e.re = !wr; e.we = wr;
                e.a = base + 32'(4 * i); e.wd = wl[32*i +: 32];
                tl.push_back(e);
            end
            if (sil) break;
            if (!wr) exp_rline[32*i +: 32] = mem[10'((base >> 2) + 32'(i))];
            if (i != BSIZE - 1) tl.push_back(idle_e());
        end
        e = idle_e(); e.done = 1; e.err = sil; e.rchk = 1; e.rline = exp_rline;
        tl.push_back(e);
    endtask

    // Compare process: one expected entry per cycle, idle when the timeline is empty.
    initial begin
        exp_t e;
        bit   prev_act = 0;
        forever begin
            @(negedge clk);
            e = (tl.size() > 0) ? tl.pop_front() : idle_e();
            chk($sformatf("bus_c%0d", cyc),
                {bus.MemRE, bus.MemWE, bus.MemA, bus.MemWD, bus.Done, bus.Error},
                {e.re, e.we, e.a, e.wd, e.done, e.err});
            if (e.rchk) chk($sformatf("rline_c%0d", cyc), bus.RLine, e.rline);
            if (bus.Done === 1'b1) begin done_cnt++; done_cyc = cyc; end
            if (bus.Error === 1'b1) begin err_cnt++; err_cyc = cyc; end
            if (bus.MemRE === 1'b1) re_cnt++;
            if ((bus.MemRE | bus.MemWE) && !prev_act) rq.push_back(cyc);
            prev_act = bus.MemRE | bus.MemWE;
        end
    end

    // Memory responder: MemValid in the k-th cycle after a request appears.
    initial begin
        int  acc = 0;
        bit  act;
        bus.MemValid = 0;
        bus.MemRD    = '0;
        forever begin
            @(negedge clk);
            act = (bus.MemRE === 1'b1) || (bus.MemWE === 1'b1);
            if (act && !silent) begin
                if (acc == int'(rwait)) begin
                    bus.MemValid = 1;
                    if (bus.MemWE) mem[bus.MemA[11:2]] = bus.MemWD;
                    else bus.MemRD = mem[bus.MemA[11:2]];
                    alog.push_back(bus.MemA);
                    acc = 0;
                end else begin
                    bus.MemValid = 0;
                    acc++;
                end
            end else begin
                bus.MemValid = inject && !act;
                bus.MemRD    = inject ? 32'hDEAD_BEEF : 32'h0;
                acc = 0;
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input bit wr, input logic [31:0] ba, input logic [LW-1:0] wl,
                       input int k, input bit hold);
        rwait = k;
        build(wr, ba, wl, k, 0);
        start_cyc = cyc;
        bus.Req = 1; bus.Write = wr; bus.BlockA = ba; bus.WLine = wl;
        repeat (BSIZE * (k + 2) + 1) next_cyc();
        if (!hold) bus.Req = 0;
    endtask

    initial begin
        int     d0;
        int     e0;
        int     r0;
        longint d1;
        longint rise;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) begin
            mem[64 + i]  = 32'hA0 + 32'(i);
            mem[96 + i]  = 32'hB0 + 32'(i);
            mem[192 + i] = 32'hC0 + 32'(i);
        end
        bus.Req = 0; bus.Write = 0; bus.BlockA = '0; bus.WLine = '0;
        #1 reset = 0;
        repeat (3) next_cyc();
        chk("rst_outputs", {bus.MemRE, bus.MemWE, bus.MemA, bus.MemWD, bus.Done, bus.Error}, '0);
        chk("rst_rline", bus.RLine, '0);
        reset = 1;
        next_cyc();

        // Read fill of 0x100, one wait cycle per word.
        alog.delete();
        d0 = done_cnt;
        run(0, 32'h100, '0, 1, 0);
        chk("read_rline", bus.RLine, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        chk("read_addr_count", alog.size(), 4);
        for (int i = 0; i < 4 && i < alog.size(); i++)
            chk($sformatf("read_addr%0d", i), alog[i], 32'h100 + 32'(4 * i));
        chk("read_latency", done_cyc - start_cyc, 12);
        chk("read_done_width", done_cnt - d0, 1);

        // Write-back with a misaligned line address.
        r0 = re_cnt;
        run(1, 32'h204, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 0);
        chk("wr_mem200", mem[128], 32'h11);
        chk("wr_mem204", mem[129], 32'h22);
        chk("wr_mem208", mem[130], 32'h33);
        chk("wr_mem20c", mem[131], 32'h44);
        chk("wr_no_re", re_cnt - r0, 0);
        chk("wr_rline_held", bus.RLine, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Stray MemValid during IDLE and GAP must be ignored.
        inject = 1;
        repeat (3) next_cyc();
        run(0, 32'h180, '0, 2, 0);
        inject = 0;
        next_cyc();
        chk("inject_rline", bus.RLine, {32'hB3, 32'hB2, 32'hB1, 32'hB0});

        // Back-to-back: Req held through Done.
        run(1, 32'h200, {32'h5D, 32'h5C, 32'h5B, 32'h5A}, 1, 1);
        d1 = done_cyc;
        run(0, 32'h200, '0, 1, 0);
        chk("b2b_rline", bus.RLine, {32'h5D, 32'h5C, 32'h5B, 32'h5A});
        rise = -1;
        foreach (rq[i]) if (rise < 0 && rq[i] > d1) rise = rq[i];
        chk("b2b_access_gap", rise - d1, 2);

        // Asynchronous reset during the first ACCESS cycle of word 2.
        build(0, 32'h300, '0, 1, 0);
        rwait = 1;
        bus.Req = 1; bus.Write = 0; bus.BlockA = 32'h300; bus.WLine = '0;
        repeat (7) next_cyc();
        #2;
        tl.delete();
        reset = 0;
        bus.Req = 0;
        #1;
        chk("arst_outputs", {bus.MemRE, bus.MemWE, bus.MemA, bus.MemWD, bus.Done, bus.Error}, '0);
        chk("arst_rline", bus.RLine, '0);
        exp_rline = '0;
        repeat (2) next_cyc();
        reset = 1;
        next_cyc();
        alog.delete();
        run(0, 32'h300, '0, 1, 0);
        chk("arst_restart_addr", (alog.size() > 0) ? alog[0] : 32'hFFFF_FFFF, 32'h300);
        chk("arst_restart_rline", bus.RLine, {32'hC3, 32'hC2, 32'hC1, 32'hC0});

`ifdef MEM_TIMEOUT_EN
        // Silent responder: Done and Error together 8 cycles after ACCESS entry.
        silent = 1;
        e0 = err_cnt;
        build(0, 32'h100, '0, 0, 1);
        start_cyc = cyc;
        bus.Req = 1; bus.Write = 0; bus.BlockA = 32'h100; bus.WLine = '0;
        repeat (TMO + 2) next_cyc();
        bus.Req = 0;
        silent = 0;
        chk("tmo_err_count", err_cnt - e0, 1);
        chk("tmo_latency", err_cyc - start_cyc, 1 + TMO);
        chk("tmo_done_with_err", done_cyc, err_cyc);
        next_cyc();
        // Response in the 8th ACCESS cycle wins over the timeout.
        e0 = err_cnt;
        run(0, 32'h100, '0, TMO - 1, 0);
        chk("tmo_edge_no_err", err_cnt - e0, 0);
        chk("tmo_edge_rline", bus.RLine, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
`else
        e0 = err_cnt;
        d0 = 0;
        repeat (4) next_cyc();
        chk("no_error_ever", err_cnt - e0, d0);
`endif

        repeat (3) next_cyc();
        chk("timeline_drained", tl.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
